ex_muldiv: RTL and testbench

Iterative multiply/divide unit for the EX stage of the MIPS integer pipeline, parametrised in operand width. It executes MULT/MULTU/DIV/DIVU and, when configured, MADD/MADDU/MSUB/MSUBU over several cycles. While it runs, it holds the pipeline through `stallreq_o`. It delivers a one-cycle HI/LO write (`hi_o`, `lo_o`, `whilo_o`) that the EX stage merges into its HILO outputs.

---
 rtl/muldiv_pkg.sv | 52 +++++
 rtl/muldiv_divstep.sv | 24 ++
 rtl/ex_muldiv.sv | 249 ++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage iterative multiply/divide unit.
//   - 3-bit operation codes (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU)
//   - FSM state enum
//   - default operand width and widest supported operand width
//   - helpers for op decoding and two's-complement absolute value
package muldiv_pkg;

  localparam int unsigned MuldivDataW = 32;
  // Widest operand the absolute-value helper supports.
  localparam int unsigned MuldivMaxW  = 64;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMadd  = 3'd4;
  localparam logic [2:0] OpMaddu = 3'd5;
  localparam logic [2:0] OpMsub  = 3'd6;
  localparam logic [2:0] OpMsubu = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } muldiv_state_e;

  // Two's-complement magnitude of a sign-extended operand. The most-negative
  // value of a narrower operand maps to 2^(W-1), which reads back correctly as
  // an unsigned W-bit magnitude.
  function automatic logic [MuldivMaxW-1:0] abs_val(input logic [MuldivMaxW-1:0] x);
    return x[MuldivMaxW-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  // Accumulating ops occupy the upper half of the op-code space.
  function automatic logic op_is_macc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OpMsub) || (op == OpMsubu);
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// muldiv_divstep: one combinational restoring-division step.
//   rem_i     : shifted partial remainder {rem, next dividend bit}, DATA_W+1 bits
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder (always < divisor)
//   qbit_o    : quotient bit produced by this step
module muldiv_divstep
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = MuldivDataW
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              qbit_o
);

  logic [DATA_W:0] w_diff;

  // rem_i < 2*divisor, so the difference sign bit alone decides the trial.
  assign w_diff = rem_i - {1'b0, divisor_i};
  assign qbit_o = ~w_diff[DATA_W];
  assign rem_o  = qbit_o ? w_diff[DATA_W-1:0] : rem_i[DATA_W-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the MIPS EX stage.
// Runs MULT/MULTU/DIV/DIVU (and MADD/MADDU/MSUB/MSUBU when the build macro
// EX_MULDIV_MACC_EN is defined) over DATA_W cycles, holding the pipeline via
// stallreq_o, then presents a one-cycle HI/LO write.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start_i, op_i        : start request and op code (sampled in IDLE only)
//   opdata1_i, opdata2_i : rs / rt operands
//   acc_hi_i, acc_lo_i   : forwarded HI/LO for accumulate ops
//   annul_i              : flush, cancels any operation
//   busy_o, stallreq_o   : unit busy / pipeline stall request
//   done_o, whilo_o      : result valid / HI-LO write enable (identical)
//   hi_o, lo_o           : result, zero outside DONE
// Supports DATA_W from 4 up to MuldivMaxW.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = MuldivDataW,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic [DATA_W-1:0] acc_hi_i,
  input  logic [DATA_W-1:0] acc_lo_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              stallreq_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o
);

  localparam int unsigned ProdW = 2 * DATA_W;

  muldiv_state_e r_state, w_state_d;

  logic [2:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  // Multiplicand for multiplies, divisor for divides.
  logic [DATA_W-1:0] r_opnd;
  // Multiply: {partial sum, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [ProdW-1:0]  r_prod;
  logic              r_neg_res;
  logic              r_neg_rem;

  logic w_legal;
  logic w_start;
  logic w_last;
  logic w_signed;
  logic w_op_div;
  logic w_div_zero;

  // ---------------------------------------------------------------------------
  // Operand decode and magnitudes
  // ---------------------------------------------------------------------------
  logic [MuldivMaxW-1:0] w_ext1, w_ext2, w_abs1, w_abs2;
  logic [DATA_W-1:0]     w_mag1, w_mag2;

  assign w_ext1 = MuldivMaxW'($signed(opdata1_i));
  assign w_ext2 = MuldivMaxW'($signed(opdata2_i));
  assign w_abs1 = abs_val(w_ext1);
  assign w_abs2 = abs_val(w_ext2);

  generate
    if (DATA_W < MuldivMaxW) begin : g_abs_hi
      logic w_unused_abs_hi;
      assign w_unused_abs_hi = ^{w_abs1[MuldivMaxW-1:DATA_W], w_abs2[MuldivMaxW-1:DATA_W]};
    end
  endgenerate

  assign w_signed   = op_is_signed(op_i);
  assign w_op_div   = op_is_div(op_i);
  assign w_div_zero = (opdata2_i == '0);
  assign w_mag1     = w_signed ? w_abs1[DATA_W-1:0] : opdata1_i;
  assign w_mag2     = w_signed ? w_abs2[DATA_W-1:0] : opdata2_i;

`ifdef EX_MULDIV_MACC_EN
  assign w_legal = 1'b1;
`else
  assign w_legal = ~op_is_macc(op_i);
  logic w_unused_acc;
  assign w_unused_acc = ^{acc_hi_i, acc_lo_i};
`endif

  assign w_start = (r_state == StIdle) & start_i & w_legal & ~annul_i;
  assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    if (annul_i) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            if (!w_op_div)       w_state_d = StMul;
            else if (w_div_zero) w_state_d = StDone;
            else                 w_state_d = StDiv;
          end
        end
        StMul, StDiv: begin
          if (w_last) w_state_d = StDone;
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   w_mul_sum;
  logic [DATA_W-1:0] w_div_rem;
  logic              w_div_qbit;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole product right.
  assign w_mul_sum = {1'b0, r_prod[ProdW-1:DATA_W]} +
                     (r_prod[0] ? {1'b0, r_opnd} : {(DATA_W + 1){1'b0}});

  muldiv_divstep #(
    .DATA_W (DATA_W)
  ) u_divstep (
    .rem_i     (r_prod[ProdW-1:DATA_W-1]),
    .divisor_i (r_opnd),
    .rem_o     (w_div_rem),
    .qbit_o    (w_div_qbit)
  );

`ifdef EX_MULDIV_MACC_EN
  logic [ProdW-1:0] r_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      r_op      <= OpMult;
      r_cnt     <= '0;
      r_opnd    <= '0;
      r_prod    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
`ifdef EX_MULDIV_MACC_EN
      r_acc     <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_op  <= op_i;
            r_cnt <= '0;
`ifdef EX_MULDIV_MACC_EN
            r_acc <= {acc_hi_i, acc_lo_i};
`endif
            if (w_op_div && w_div_zero) begin
              // Quotient all ones, remainder the raw dividend, no sign fix-up.
              r_opnd    <= '0;
              r_prod    <= {opdata1_i, {DATA_W{1'b1}}};
              r_neg_res <= 1'b0;
              r_neg_rem <= 1'b0;
            end else if (w_op_div) begin
              r_opnd    <= w_mag2;
              r_prod    <= {{DATA_W{1'b0}}, w_mag1};
              r_neg_res <= w_signed & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg_rem <= w_signed & opdata1_i[DATA_W-1];
            end else begin
              r_opnd    <= w_mag1;
              r_prod    <= {{DATA_W{1'b0}}, w_mag2};
              r_neg_res <= w_signed & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg_rem <= 1'b0;
            end
          end
        end
        StMul: begin
          r_prod <= {w_mul_sum, r_prod[DATA_W-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        StDiv: begin
          r_prod <= {w_div_rem, r_prod[DATA_W-2:0], w_div_qbit};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result fix-up
  // ---------------------------------------------------------------------------
  logic [ProdW-1:0]  w_prod_fix;
  logic [ProdW-1:0]  w_mul_res;
  logic [DATA_W-1:0] w_quot, w_rem;

  assign w_prod_fix = r_neg_res ? (~r_prod + 1'b1) : r_prod;
  assign w_quot     = r_neg_res ? (~r_prod[DATA_W-1:0] + 1'b1) : r_prod[DATA_W-1:0];
  assign w_rem      = r_neg_rem ? (~r_prod[ProdW-1:DATA_W] + 1'b1) : r_prod[ProdW-1:DATA_W];

`ifdef EX_MULDIV_MACC_EN
  logic [ProdW-1:0] w_macc_res;
  assign w_macc_res = op_is_sub(r_op) ? (r_acc - w_prod_fix) : (r_acc + w_prod_fix);
  assign w_mul_res  = op_is_macc(r_op) ? w_macc_res : w_prod_fix;
`else
  assign w_mul_res  = w_prod_fix;
`endif

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o     = (r_state != StIdle);
    stallreq_o = w_start | (r_state == StMul) | (r_state == StDiv);
    done_o     = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    if (r_state == StDone) begin
      done_o = ~annul_i;
      if (op_is_div(r_op)) begin
        hi_o = w_rem;
        lo_o = w_quot;
      end else begin
        hi_o = w_mul_res[ProdW-1:DATA_W];
        lo_o = w_mul_res[DATA_W-1:0];
      end
    end
  end

  assign whilo_o = done_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv at DATA_W = 32.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i, acc_hi_i, acc_lo_i;
  logic        annul_i;
  logic        busy_o, stallreq_o, done_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .acc_hi_i   (acc_hi_i),
    .acc_lo_i   (acc_lo_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 64'(busy_o), 64'd0);
    check({tag, " stall"}, 64'(stallreq_o), 64'd0);
    check({tag, " done"}, 64'(done_o), 64'd0);
    check({tag, " whilo"}, 64'(whilo_o), 64'd0);
    check({tag, " hi"}, 64'(hi_o), 64'd0);
    check({tag, " lo"}, 64'(lo_o), 64'd0);
  endtask

  // Launch one op at cycle 0 and check the DONE cycle, stall profile and result.
  // With poke set, a second start is driven mid-operation and must be ignored.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ah, input logic [31:0] al,
                       input int exp_cyc, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input bit poke);
    int cyc;
    bit stall_ok;
    @(negedge clk);
    op_i = op; opdata1_i = a; opdata2_i = b; acc_hi_i = ah; acc_lo_i = al; start_i = 1'b1;
    #1 stall_ok = stallreq_o;
    @(negedge clk);
    cyc = 1;
    while (!done_o && cyc < 100) begin
      if (poke && cyc == 5) begin
        start_i = 1'b1; op_i = OpMult; opdata1_i = 32'd6; opdata2_i = 32'd7;
      end else begin
        start_i = 1'b0;
      end
      #1 stall_ok &= stallreq_o;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " stall before done"}, 64'(stall_ok), 64'd1);
    check({tag, " stall at done"}, 64'(stallreq_o), 64'd0);
    check({tag, " whilo"}, 64'(whilo_o), 64'd1);
    check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(done_o), 64'd0);
    check({tag, " idle after"}, 64'(busy_o), 64'd0);
    check({tag, " hi zero after"}, 64'(hi_o), 64'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = OpMult;
    opdata1_i = '0; opdata2_i = '0; acc_hi_i = '0; acc_lo_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    do_op("mult neg",  OpMult,  32'hFFFFFFFE, 32'h3, 0, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    do_op("multu max", OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 33,
          32'hFFFFFFFE, 32'h00000001, 0);
    do_op("mult negneg", OpMult, 32'hFFFFFFFD, 32'hFFFFFFFB, 0, 0, 33, 32'h0, 32'd15, 0);
    do_op("divu",      OpDivu,  32'd100, 32'd7, 0, 0, 33, 32'd2, 32'd14, 1);
    do_op("div negdd", OpDiv,   32'hFFFFFFF9, 32'd2, 0, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    do_op("div negdv", OpDiv,   32'd7, 32'hFFFFFFFE, 0, 0, 33, 32'd1, 32'hFFFFFFFD, 0);
    do_op("div ovf",   OpDiv,   32'h80000000, 32'hFFFFFFFF, 0, 0, 33, 32'h0, 32'h80000000, 0);
    do_op("divu zero", OpDivu,  32'd5, 32'd0, 0, 0, 1, 32'd5, 32'hFFFFFFFF, 0);
    do_op("div zero",  OpDiv,   32'hFFFFFFF9, 32'd0, 0, 0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);

    // Annul at cycle 10 of a MULTU.
    @(negedge clk);
    op_i = OpMultu; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("annul pre busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul busy", 64'(busy_o), 64'd0);
    check("annul stall", 64'(stallreq_o), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (whilo_o) cnt++;
    end
    check("annul no whilo", 64'(cnt), 64'd0);

    // Start and annul together: nothing starts.
    @(negedge clk);
    op_i = OpDivu; opdata1_i = 32'd8; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    #1 check("start+annul stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("start+annul busy", 64'(busy_o), 64'd0);

    // Annul during DONE suppresses the write.
    @(negedge clk);
    op_i = OpDivu; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("done annul busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    #1;
    check("done annul done", 64'(done_o), 64'd0);
    check("done annul whilo", 64'(whilo_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    check("done annul idle", 64'(busy_o), 64'd0);

`ifdef EX_MULDIV_MACC_EN
    do_op("msubu", OpMsubu, 32'd3, 32'd4, 32'd0, 32'd10, 33, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    do_op("madd",  OpMadd,  32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, 33, 32'd0, 32'd4, 0);
`else
    @(negedge clk);
    op_i = OpMsubu; opdata1_i = 32'd3; opdata2_i = 32'd4;
    acc_hi_i = 32'd0; acc_lo_i = 32'd10; start_i = 1'b1;
    #1 check("msubu illegal stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) cnt++;
    end
    check("msubu illegal done", 64'(cnt), 64'd0);
    check("msubu illegal busy", 64'(busy_o), 64'd0);
`endif

    // Reset in the middle of a divide.
    @(negedge clk);
    op_i = OpDivu; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("rst pre busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst mid div");
    do_op("mult after rst", OpMult, 32'd6, 32'd7, 0, 0, 33, 32'd0, 32'd42, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
